// File: rtl/proc_pkg.sv
// ============================================================================
// Module      : proc_pkg
// Description : Shared constants and helpers for the processor front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam int          OPCODE_MSB       = 31;
  localparam int          OPCODE_LSB       = 27;
  localparam int          FUNC_MSB         = 6;
  localparam int          FUNC_LSB         = 2;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-addressed increment; wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// Module      : fetch_skid_buf
// Description : Single-entry holding register for a fetched word and its PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buf
  import proc_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic [31:0] insn_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] insn_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] insn_q,  insn_d;
  logic [31:0] pc_q,    pc_d;

  // Flush beats load beats unload; load and unload never coincide in the fetch stage.
  always_comb begin
    valid_d = valid_q;
    insn_d  = insn_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
      insn_d  = NOP_INSN;
    end else if (load_i) begin
      valid_d = 1'b1;
      insn_d  = insn_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      insn_q  <= NOP_INSN;
      pc_q    <= 32'd0;
    end else begin
      valid_q <= valid_d;
      insn_q  <= insn_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign insn_o  = insn_q;
  assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : PC, synchronous imem interface and IF/ID register with skid.
//               Optional FETCH_PERF_EN adds fetched/bubble cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_W = 12
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]            imem_q_i,
  output logic                   if_valid_o,
  output logic [31:0]            if_insn_o,
  output logic [31:0]            if_pc_o,
  output logic [31:0]            if_pc_plus1_o,
  output logic [4:0]             if_opcode_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]            perf_fetched_o,
  output logic [31:0]            perf_bubbles_o,
`endif
  output logic [4:0]             if_func_o
);

  logic [31:0] pc_q,        pc_d;
  logic        resp_live_q, resp_live_d;
  logic [31:0] resp_pc_q,   resp_pc_d;
  logic        if_valid_q,  if_valid_d;
  logic [31:0] if_insn_q,   if_insn_d;
  logic [31:0] if_pc_q,     if_pc_d;

  logic        skid_valid;
  logic [31:0] skid_insn;
  logic [31:0] skid_pc;
  logic        skid_flush;
  logic        skid_load;
  logic        skid_unload;
  logic        advance;

  assign advance     = !redirect_valid_i && !stall_i;
  assign skid_flush  = redirect_valid_i;
  assign skid_load   = !redirect_valid_i && stall_i && resp_live_q;
  assign skid_unload = advance && skid_valid;

  fetch_skid_buf u_skid (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .flush_i  (skid_flush),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .insn_i   (imem_q_i),
    .pc_i     (resp_pc_q),
    .valid_o  (skid_valid),
    .insn_o   (skid_insn),
    .pc_o     (skid_pc)
  );

  always_comb begin
    pc_d        = pc_q;
    resp_live_d = resp_live_q;
    resp_pc_d   = resp_pc_q;
    if_valid_d  = if_valid_q;
    if_insn_d   = if_insn_q;
    if_pc_d     = if_pc_q;
    if (redirect_valid_i) begin
      pc_d        = redirect_pc_i;
      resp_live_d = 1'b0;
      if_valid_d  = 1'b0;
      if_insn_d   = NOP_INSN;
    end else if (stall_i) begin
      // The address re-issued while stalled returns a word nobody will consume.
      resp_live_d = 1'b0;
    end else begin
      if (skid_valid) begin
        if_valid_d = 1'b1;
        if_insn_d  = skid_insn;
        if_pc_d    = skid_pc;
      end else begin
        if_valid_d = resp_live_q;
        if_insn_d  = resp_live_q ? imem_q_i : NOP_INSN;
        if_pc_d    = resp_pc_q;
      end
      pc_d        = pc_inc(pc_q);
      resp_pc_d   = pc_q;
      resp_live_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q        <= RESET_PC;
      resp_live_q <= 1'b0;
      resp_pc_q   <= 32'd0;
      if_valid_q  <= 1'b0;
      if_insn_q   <= NOP_INSN;
      if_pc_q     <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      resp_live_q <= resp_live_d;
      resp_pc_q   <= resp_pc_d;
      if_valid_q  <= if_valid_d;
      if_insn_q   <= if_insn_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign imem_addr_o   = pc_q[IMEM_ADDR_W-1:0];
  assign if_valid_o    = if_valid_q;
  assign if_insn_o     = if_insn_q;
  assign if_pc_o       = if_pc_q;
  assign if_pc_plus1_o = pc_inc(if_pc_q);
  assign if_opcode_o   = if_insn_q[OPCODE_MSB:OPCODE_LSB];
  assign if_func_o     = if_insn_q[FUNC_MSB:FUNC_LSB];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (if_valid_q) perf_fetched_d = sat_inc(perf_fetched_q);
    else            perf_bubbles_d = sat_inc(perf_bubbles_q);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_bubbles_o = perf_bubbles_q;
`endif

  // A stall always drains the live response into the skid, so both can never be pending.
  a_no_skid_overrun : assert property (@(posedge clock_i) disable iff (reset_i)
    !(stall_i && !redirect_valid_i && resp_live_q && skid_valid));

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench; two DUTs (RESET_PC 0 and FFFFFFFF).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [AW-1:0] imem_addr_w [2];
  logic [31:0]   imem_q_r    [2];
  logic          if_valid_w  [2];
  logic [31:0]   if_insn_w   [2];
  logic [31:0]   if_pc_w     [2];
  logic [31:0]   if_pc1_w    [2];
  logic [4:0]    if_opc_w    [2];
  logic [4:0]    if_func_w   [2];
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_f_w    [2];
  logic [31:0]   perf_b_w    [2];
`endif

  logic [31:0] mem [2][1<<AW];
  logic [31:0] rst_pc [2];

  // Reference model: stream of delivered addresses plus remaining bubble count.
  logic        m_valid [2];
  logic [31:0] m_insn  [2];
  logic [31:0] m_pc    [2];
  int          m_pend  [2];
  logic [31:0] m_next  [2];
  logic [31:0] m_fet   [2];
  logic [31:0] m_bub   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(AW)) u_dut0 (
    .clock_i(clk), .reset_i(reset), .stall_i(stall),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_addr_o(imem_addr_w[0]), .imem_q_i(imem_q_r[0]),
    .if_valid_o(if_valid_w[0]), .if_insn_o(if_insn_w[0]), .if_pc_o(if_pc_w[0]),
    .if_pc_plus1_o(if_pc1_w[0]), .if_opcode_o(if_opc_w[0]),
`ifdef FETCH_PERF_EN
    .perf_fetched_o(perf_f_w[0]), .perf_bubbles_o(perf_b_w[0]),
`endif
    .if_func_o(if_func_w[0])
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .IMEM_ADDR_W(AW)) u_dut1 (
    .clock_i(clk), .reset_i(reset), .stall_i(stall),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_addr_o(imem_addr_w[1]), .imem_q_i(imem_q_r[1]),
    .if_valid_o(if_valid_w[1]), .if_insn_o(if_insn_w[1]), .if_pc_o(if_pc_w[1]),
    .if_pc_plus1_o(if_pc1_w[1]), .if_opcode_o(if_opc_w[1]),
`ifdef FETCH_PERF_EN
    .perf_fetched_o(perf_f_w[1]), .perf_bubbles_o(perf_b_w[1]),
`endif
    .if_func_o(if_func_w[1])
  );

  // Synchronous instruction memories.
  always @(posedge clk) begin
    imem_q_r[0] <= mem[0][imem_addr_w[0]];
    imem_q_r[1] <= mem[1][imem_addr_w[1]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic s,
                            input logic rv, input logic [31:0] rpc);
    if (r) begin
      m_valid[i] = 1'b0; m_insn[i] = 32'd0; m_pc[i] = 32'd0;
      m_pend[i]  = 1;    m_next[i] = rst_pc[i];
      m_fet[i]   = 32'd0; m_bub[i] = 32'd0;
    end else begin
      if (m_valid[i]) m_fet[i] = m_fet[i] + 1;
      else            m_bub[i] = m_bub[i] + 1;
      if (rv) begin
        m_valid[i] = 1'b0; m_insn[i] = 32'd0; m_pend[i] = 1; m_next[i] = rpc;
      end else if (!s) begin
        if (m_pend[i] > 0) begin
          m_pend[i]--; m_valid[i] = 1'b0; m_insn[i] = 32'd0;
        end else begin
          m_valid[i] = 1'b1;
          m_pc[i]    = m_next[i];
          m_insn[i]  = mem[i][m_next[i] % (1 << AW)];
          m_next[i]  = m_next[i] + 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input int i);
    logic [31:0] insn;
    insn = if_insn_w[i];
    check_eq($sformatf("valid%0d", i), {31'd0, if_valid_w[i]}, {31'd0, m_valid[i]});
    check_eq($sformatf("insn%0d", i), insn, m_insn[i]);
    if (m_valid[i]) check_eq($sformatf("pc%0d", i), if_pc_w[i], m_pc[i]);
    check_eq($sformatf("pc_plus1_%0d", i), if_pc1_w[i], if_pc_w[i] + 32'd1);
    check_eq($sformatf("opcode%0d", i), {27'd0, if_opc_w[i]}, {27'd0, insn[31:27]});
    check_eq($sformatf("func%0d", i), {27'd0, if_func_w[i]}, {27'd0, insn[6:2]});
`ifdef FETCH_PERF_EN
    check_eq($sformatf("perf_fetched%0d", i), perf_f_w[i], m_fet[i]);
    check_eq($sformatf("perf_bubbles%0d", i), perf_b_w[i], m_bub[i]);
`endif
  endtask

  task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    reset = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, r, s, rv, rpc);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  initial begin
    rst_pc[0] = 32'h0000_0000;
    rst_pc[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < (1 << AW); a++)
        mem[i][a] = (a < 64) ? (32'h100 + a) : $urandom;

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_eq("reset_valid0", {31'd0, if_valid_w[0]}, 32'd0);
    check_eq("reset_insn0", if_insn_w[0], 32'd0);

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_eq("first_pc0", if_pc_w[0], 32'd0);
    check_eq("first_insn0", if_insn_w[0], 32'h100);
    check_eq("first_pc1", if_pc_w[1], 32'hFFFF_FFFF);
    cycle(0, 0, 0, 0);
    check_eq("wrap_pc1", if_pc_w[1], 32'd0);
    cycle(0, 0, 0, 0);
    check_eq("wrap_pc1_next", if_pc_w[1], 32'd1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0);
      check_eq("stall_hold_pc", if_pc_w[0], 32'd4);
    end
    for (int k = 5; k <= 10; k++) begin
      cycle(0, 0, 0, 0);
      check_eq("post_stall_pc", if_pc_w[0], k);
    end

    cycle(0, 0, 1, 32'd40);
    cycle(0, 0, 0, 0);
    check_eq("redirect_bubble", {31'd0, if_valid_w[0]}, 32'd0);
    cycle(0, 0, 0, 0);
    check_eq("redirect_target", if_pc_w[0], 32'd40);
    cycle(0, 0, 0, 0);
    check_eq("redirect_next", if_pc_w[0], 32'd41);

    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'd20);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_eq("stall_redirect_target", if_pc_w[0], 32'd20);

    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check_eq("reset_in_stall_valid", {31'd0, if_valid_w[0]}, 32'd0);

    for (int k = 0; k < 3000; k++) begin
      logic        r, s, rv;
      logic [31:0] t;
      r  = ($urandom_range(0, 99) == 0);
      rv = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + $urandom_range(0, 3)) : $urandom;
      cycle(r, s, rv, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined processor: owns the program counter, drives the synchronous instruction memory, and fills the IF/ID pipeline register that feeds the opcode/function decoder and control unit. It absorbs the one-cycle imem read latency, holds state under a hazard stall without dropping the in-flight word, and flushes on a branch/jump redirect from downstream.

## Interface
- RESET_PC, 0: PC value loaded on reset (word address).
- IMEM_ADDR_W, 12: width of the imem address bus.

- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold IF/ID and PC this cycle
- redirect_valid  in  1  taken branch / jump / jal / jr resolved this cycle
- redirect_pc  in  32  target word address
- imem_addr  out  IMEM_ADDR_W  pc[IMEM_ADDR_W-1:0], combinational from PC register
- imem_q  in  32  instruction word for the address presented the previous cycle
- if_valid  out  1  IF/ID holds a live instruction
- if_insn  out  32  instruction; 0 whenever if_valid=0
- if_pc  out  32  address of if_insn
- if_pc_plus1  out  32  if_pc+1, combinational
- if_opcode  out  5  if_insn[31:27], combinational, to control decoder
- if_func  out  5  if_insn[6:2], combinational, to control decoder

## Operation
- State: pc, resp_live (imem_q this cycle is a live response), resp_pc, skid_valid/skid_insn/skid_pc, IF/ID register.
- Priority per edge: reset > redirect > stall > advance.
- Reset: pc<=RESET_PC; resp_live, skid_valid, if_valid <=0; if_insn, if_pc <=0.
- Redirect (overrides stall): pc<=redirect_pc; resp_live<=0; skid_valid<=0; if_valid<=0, if_insn<=0. In-flight word discarded.
- Stall: pc and IF/ID held; if resp_live, {imem_q, resp_pc} captured into skid, skid_valid<=1; resp_live<=0 (re-issued address is ignored).
- Advance: if skid_valid, IF/ID<=skid contents, skid_valid<=0; else IF/ID<={imem_q, resp_pc}, if_valid<=resp_live. Then pc<=pc+1, resp_pc<=pc, resp_live<=1.
- PC is word-addressed; pc+1 wraps mod 2^32; imem_addr truncates.
- Invariant: stall with resp_live=1 and skid_valid=1 never occurs (assertion).

## Timing
- Latency: address presented cycle N -> imem_q cycle N+1 -> if_valid/if_insn visible cycle N+2.
- First live instruction after reset deassert (cycle 0): if_valid=1 in cycle 2, if_pc=RESET_PC.
- Steady state: one instruction per cycle, no bubble on stall release (skid supplies the held word, re-issued PC arrives the following cycle).
- Redirect in cycle N: if_valid=0 in N+1 and N+2; target instruction in N+3 (two-bubble penalty).
- Stall and redirect together: redirect wins.
- Reset mid-stall or mid-redirect: reset wins, full reset state.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, count of cycles with if_valid=1) and perf_bubbles (32, count of cycles with if_valid=0 outside reset); both saturate at 2^32-1 and clear on reset.
- Undefined: ports and counters absent; fetch behaviour identical.

## Structure
- Shared package proc_pkg: OPCODE_MSB/LSB (31/27), FUNC_MSB/LSB (6/2), NOP_INSN (32'h0), default RESET_PC.
- One sub-module: fetch_skid_buf (single-entry holding register with load/unload/flush).

## Test plan
- Reset release, imem[i]=i+32'h100: if_valid=1 from cycle 2, if_pc 0,1,2,..., if_insn 32'h100,32'h101,...
- Stall for 3 cycles while if_pc=4: if_* held at 4 throughout; after release if_pc 5,6,7 with no gap.
- Redirect to 40 while if_pc=10: two cycles if_valid=0 and if_insn=0, then if_pc=40, 41.
- Stall and redirect asserted together to 20: redirect honoured, skid cleared, if_pc=20 three cycles later.
- Reset asserted during stall with skid full: next cycle if_valid=0, pc=RESET_PC, stale skid word never emitted.
- RESET_PC=32'hFFFFFFFF: if_pc sequence FFFFFFFF, 0, 1; with FETCH_PERF_EN, perf_fetched matches delivered count.
